// File: rtl/jtcop_mix_pkg.sv
// jtcop_mix_pkg
// Shared definitions for the layer mixer:
//   MIX_IDW         layer-ID width (3 bits covers up to 8 layers)
//   ORDER_PADW      width an order vector is zero-padded to for byte readout
//   st_sel_e        st_addr[7:4] select codes for the status port
//   identity_order  order vector with slot k holding layer k
//   order_byte      byte N of a padded order vector
package jtcop_mix_pkg;

    localparam int MIX_IDW    = 3;
    localparam int ORDER_PADW = 64;  // 8 bytes, addressed by st_addr[2:0]

    typedef enum logic [3:0] {
        ST_ACTIVE = 4'd0,
        ST_SHADOW = 4'd1,
        ST_FRAME  = 4'd2
    } st_sel_e;

    function automatic logic [ORDER_PADW-1:0] identity_order(input int nlayers);
        logic [ORDER_PADW-1:0] o;
        o = '0;
        for (int k = 0; k < 8; k++) begin
            if (k < nlayers) o[k*MIX_IDW +: MIX_IDW] = MIX_IDW'(k);
        end
        return o;
    endfunction

    function automatic logic [7:0] order_byte(input logic [ORDER_PADW-1:0] o,
                                              input logic [2:0]            sel);
        return o[{sel, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/jtcop_mix_sel.sv
// jtcop_mix_sel
// Combinational priority logic for the mixer, two independent halves:
//   Stage-2 half: lyr_pxl + order  -> slot_pxl (pixels in priority order,
//                 zero for out-of-range IDs) and slot_opaque flags.
//   Stage-3 half: sel_slot_pxl/sel_slot_opaque/sel_order (registered copy of
//                 the stage-2 results) -> sel_pxl/sel_id of the winning slot,
//                 falling back to the last slot (backdrop) when none is opaque.
module jtcop_mix_sel
    import jtcop_mix_pkg::*;
#(
    parameter int NLAYERS = 4,
    parameter int PW      = 8,
    parameter int IDW     = 3
) (
    input  logic [NLAYERS*PW-1:0]  lyr_pxl,
    input  logic [NLAYERS*IDW-1:0] order,
    output logic [NLAYERS*PW-1:0]  slot_pxl,
    output logic [NLAYERS-1:0]     slot_opaque,

    input  logic [NLAYERS*PW-1:0]  sel_slot_pxl,
    input  logic [NLAYERS-1:0]     sel_slot_opaque,
    input  logic [NLAYERS*IDW-1:0] sel_order,
    output logic [PW-1:0]          sel_pxl,
    output logic [IDW-1:0]         sel_id
);

    logic [IDW-1:0] slot_id;

    // Reorder layers into priority slots. An ID past the last layer reads as
    // a zero pixel, which makes it transparent and a black backdrop.
    // NOTE: every always_comb output gets a default before any branch so no
    // path can leave it unassigned and infer a latch.
    always_comb begin
        slot_pxl    = '0;
        slot_opaque = '0;
        slot_id     = '0;
        for (int s = 0; s < NLAYERS; s++) begin
            slot_id = order[s*IDW +: IDW];
            if (int'(slot_id) < NLAYERS) begin
                slot_pxl[s*PW +: PW] = lyr_pxl[int'(slot_id)*PW +: PW];
            end
            slot_opaque[s] = slot_pxl[s*PW +: 4] != 4'd0;
        end
    end

    // Start from the backdrop and walk slots from bottom to top, so the
    // lowest-numbered opaque slot is the last one to overwrite the result.
    always_comb begin
        sel_pxl = sel_slot_pxl[(NLAYERS-1)*PW +: PW];
        sel_id  = sel_order[(NLAYERS-1)*IDW +: IDW];
        for (int s = NLAYERS - 1; s >= 0; s--) begin
            if (sel_slot_opaque[s]) begin
                sel_pxl = sel_slot_pxl[s*PW +: PW];
                sel_id  = sel_order[s*IDW +: IDW];
            end
        end
    end

endmodule

// File: rtl/jtcop_layer_mix.sv
// jtcop_layer_mix
// Three-stage layer priority mixer with frame-synchronised priority order.
//   clk, rst            single clock, synchronous active-high reset
//   pxl_cen             pixel enable; pipeline stages advance only when high
//   LHBL, LVBL          active-low blanking aligned with pxl_in
//   pxl_in, gfx_en      layer pixels (layer k at [k*PW +: PW]), per-layer enable
//   order_in, order_we  new priority order (slot 0 topmost) and its write strobe
//   pxl_out, lyr_out    mixed pixel and the ID of the layer that produced it
//   LHBL_dly, LVBL_dly  blanking delayed to line up with pxl_out
//   st_addr, st_dout    status readout (orders, frame counter), 1 clk latency
// Order writes land in a shadow register and move to the active order at the
// start of vertical blank, so priorities never change mid-frame.
module jtcop_layer_mix
    import jtcop_mix_pkg::*;
#(
    parameter int NLAYERS = 4,
    parameter int PW      = 8,
    parameter int IDW     = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   pxl_cen,
    input  logic                   LHBL,
    input  logic                   LVBL,
    input  logic [NLAYERS*PW-1:0]  pxl_in,
    input  logic [NLAYERS-1:0]     gfx_en,
    input  logic [NLAYERS*IDW-1:0] order_in,
    input  logic                   order_we,
    output logic [PW-1:0]          pxl_out,
    output logic [IDW-1:0]         lyr_out,
    output logic                   LHBL_dly,
    output logic                   LVBL_dly,
    input  logic [7:0]             st_addr,
    output logic [7:0]             st_dout
);

    localparam int OW = NLAYERS * IDW;
    localparam logic [ORDER_PADW-1:0] ID_FULL  = identity_order(NLAYERS);
    localparam logic [OW-1:0]         ID_ORDER = ID_FULL[OW-1:0];

    // Stage 1: enabled layer pixels
    logic [NLAYERS*PW-1:0]  s1_pxl_q, s1_pxl_d;
    logic                   s1_hbl_q, s1_hbl_d, s1_vbl_q, s1_vbl_d;
    // Stage 2: pixels in slot order plus opaque flags
    logic [NLAYERS*PW-1:0]  s2_slot_pxl_q, s2_slot_pxl_d;
    logic [NLAYERS-1:0]     s2_opaque_q, s2_opaque_d;
    logic [OW-1:0]          s2_order_q, s2_order_d;
    logic                   s2_hbl_q, s2_hbl_d, s2_vbl_q, s2_vbl_d;
    // Stage 3: output
    logic [PW-1:0]          pxl_q, pxl_d;
    logic [IDW-1:0]         lyr_q, lyr_d;
    logic                   hdly_q, hdly_d, vdly_q, vdly_d;
    // Order control and status
    logic [OW-1:0]          shadow_q, shadow_d, active_q, active_d;
    logic                   lvbl_last_q, lvbl_last_d;
    logic [7:0]             frame_q, frame_d;
    logic [7:0]             st_q, st_d;

    logic [NLAYERS*PW-1:0]  slot_pxl;
    logic [NLAYERS-1:0]     slot_opaque;
    logic [PW-1:0]          sel_pxl;
    logic [IDW-1:0]         sel_id;
    logic                   vbl_fall;
    logic [ORDER_PADW-1:0]  active_pad, shadow_pad;
    logic                   st_unused;

    jtcop_mix_sel #(
        .NLAYERS (NLAYERS),
        .PW      (PW),
        .IDW     (IDW)
    ) u_sel (
        .lyr_pxl         (s1_pxl_q),
        .order           (active_q),
        .slot_pxl        (slot_pxl),
        .slot_opaque     (slot_opaque),
        .sel_slot_pxl    (s2_slot_pxl_q),
        .sel_slot_opaque (s2_opaque_q),
        .sel_order       (s2_order_q),
        .sel_pxl         (sel_pxl),
        .sel_id          (sel_id)
    );

    // Pixel pipeline
    always_comb begin
        s1_pxl_d      = s1_pxl_q;
        s1_hbl_d      = s1_hbl_q;
        s1_vbl_d      = s1_vbl_q;
        s2_slot_pxl_d = s2_slot_pxl_q;
        s2_opaque_d   = s2_opaque_q;
        s2_order_d    = s2_order_q;
        s2_hbl_d      = s2_hbl_q;
        s2_vbl_d      = s2_vbl_q;
        pxl_d         = pxl_q;
        lyr_d         = lyr_q;
        hdly_d        = hdly_q;
        vdly_d        = vdly_q;
        if (pxl_cen) begin
            for (int k = 0; k < NLAYERS; k++) begin
                s1_pxl_d[k*PW +: PW] = gfx_en[k] ? pxl_in[k*PW +: PW] : '0;
            end
            s1_hbl_d      = LHBL;
            s1_vbl_d      = LVBL;
            s2_slot_pxl_d = slot_pxl;
            s2_opaque_d   = slot_opaque;
            s2_order_d    = active_q;
            s2_hbl_d      = s1_hbl_q;
            s2_vbl_d      = s1_vbl_q;
            hdly_d        = s2_hbl_q;
            vdly_d        = s2_vbl_q;
            // During blanking the pixel is black and the layer ID is held.
            if (s2_hbl_q && s2_vbl_q) begin
                pxl_d = sel_pxl;
                lyr_d = sel_id;
            end else begin
                pxl_d = '0;
            end
        end
    end

    // Order registers and frame counter run on every clk, not on pxl_cen.
    assign vbl_fall = lvbl_last_q & ~LVBL;

    always_comb begin
        lvbl_last_d = LVBL;
        shadow_d    = order_we ? order_in : shadow_q;
        active_d    = active_q;
        // A write while LVBL is low goes straight to the active order; this
        // also gives a write coinciding with the falling edge priority over
        // the older shadow value.
        if (order_we && !LVBL) begin
            active_d = order_in;
        end else if (vbl_fall) begin
            active_d = shadow_q;
        end
        frame_d = vbl_fall ? frame_q + 8'd1 : frame_q;
    end

    // Status readout
    assign active_pad = {{(ORDER_PADW-OW){1'b0}}, active_q};
    assign shadow_pad = {{(ORDER_PADW-OW){1'b0}}, shadow_q};
    assign st_unused  = st_addr[3];

    always_comb begin
        st_d = 8'hff;
        case (st_addr[7:4])
            ST_ACTIVE: st_d = order_byte(active_pad, st_addr[2:0]);
            ST_SHADOW: st_d = order_byte(shadow_pad, st_addr[2:0]);
            ST_FRAME:  st_d = frame_q;
            default:   st_d = 8'hff;
        endcase
    end

    // NOTE: sequential state is updated with non-blocking assignments only,
    // so every flop samples the pre-edge value of every other flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_pxl_q      <= '0;
            s1_hbl_q      <= 1'b0;
            s1_vbl_q      <= 1'b0;
            s2_slot_pxl_q <= '0;
            s2_opaque_q   <= '0;
            s2_order_q    <= '0;
            s2_hbl_q      <= 1'b0;
            s2_vbl_q      <= 1'b0;
            pxl_q         <= '0;
            lyr_q         <= '0;
            hdly_q        <= 1'b0;
            vdly_q        <= 1'b0;
            shadow_q      <= ID_ORDER;
            active_q      <= ID_ORDER;
            lvbl_last_q   <= 1'b1;
            frame_q       <= 8'd0;
            st_q          <= 8'd0;
        end else begin
            s1_pxl_q      <= s1_pxl_d;
            s1_hbl_q      <= s1_hbl_d;
            s1_vbl_q      <= s1_vbl_d;
            s2_slot_pxl_q <= s2_slot_pxl_d;
            s2_opaque_q   <= s2_opaque_d;
            s2_order_q    <= s2_order_d;
            s2_hbl_q      <= s2_hbl_d;
            s2_vbl_q      <= s2_vbl_d;
            pxl_q         <= pxl_d;
            lyr_q         <= lyr_d;
            hdly_q        <= hdly_d;
            vdly_q        <= vdly_d;
            shadow_q      <= shadow_d;
            active_q      <= active_d;
            lvbl_last_q   <= lvbl_last_d;
            frame_q       <= frame_d;
            st_q          <= st_d;
        end
    end

    assign pxl_out  = pxl_q;
    assign lyr_out  = lyr_q;
    assign LHBL_dly = hdly_q;
    assign LVBL_dly = vdly_q;
    assign st_dout  = st_q;

endmodule

// File: tb/tb_jtcop_layer_mix.sv
// Self-checking bench for jtcop_layer_mix (NLAYERS=4, PW=8, IDW=3).
module tb_jtcop_layer_mix;

    localparam int NL = 4;

    logic        clk = 1'b0;
    logic        rst, pxl_cen, LHBL, LVBL, order_we;
    logic [31:0] pxl_in;
    logic [3:0]  gfx_en;
    logic [11:0] order_in;
    logic [7:0]  st_addr;
    logic [7:0]  pxl_out, st_dout;
    logic [2:0]  lyr_out;
    logic        LHBL_dly, LVBL_dly;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    jtcop_layer_mix dut (
        .clk      (clk),
        .rst      (rst),
        .pxl_cen  (pxl_cen),
        .LHBL     (LHBL),
        .LVBL     (LVBL),
        .pxl_in   (pxl_in),
        .gfx_en   (gfx_en),
        .order_in (order_in),
        .order_we (order_we),
        .pxl_out  (pxl_out),
        .lyr_out  (lyr_out),
        .LHBL_dly (LHBL_dly),
        .LVBL_dly (LVBL_dly),
        .st_addr  (st_addr),
        .st_dout  (st_dout)
    );

    typedef struct {
        logic [31:0] pxl;
        logic [3:0]  en;
        logic        h;
        logic        v;
        logic [7:0]  exp_pxl;
        logic [2:0]  exp_lyr;
    } vec_t;

    typedef struct {
        logic [31:0] pxl;
        logic [3:0]  en;
        logic        h;
        logic        v;
    } rec_t;

    vec_t vecs[10];
    rec_t hist[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Reference: scan the priority list top to bottom; first opaque enabled
    // in-range layer wins, otherwise the last slot is the backdrop.
    function automatic logic [10:0] ref_mix(input logic [31:0] p, input logic [3:0] en,
                                            input logic [11:0] ord);
        logic [2:0] id;
        logic [7:0] px;
        for (int s = 0; s < NL; s++) begin
            id = ord[s*3 +: 3];
            if (id < NL) begin
                px = en[id] ? p[id*8 +: 8] : 8'h00;
                if (px[3:0] != 4'h0) return {id, px};
            end
        end
        id = ord[9 +: 3];
        px = 8'h00;
        if (id < NL && en[id]) px = p[id*8 +: 8];
        return {id, px};
    endfunction

    initial begin
        #1000000;
        $display("FAIL timeout");
        $fatal(1, "bench timeout");
    end

    initial begin
        logic [11:0] rnd_order;
        logic [10:0] r;
        logic [7:0]  exp_p, byte_v;
        logic [2:0]  exp_l;
        logic        exp_h, exp_v;
        rec_t        rec;

        vecs[0] = '{32'h44332211, 4'hf, 1'b1, 1'b1, 8'h11, 3'd0};
        vecs[1] = '{32'h47352010, 4'hf, 1'b1, 1'b1, 8'h35, 3'd2};
        vecs[2] = '{32'h40302010, 4'hf, 1'b1, 1'b1, 8'h40, 3'd3};
        vecs[3] = '{32'h40302011, 4'he, 1'b1, 1'b1, 8'h40, 3'd3};
        vecs[4] = '{32'h40302011, 4'he, 1'b0, 1'b1, 8'h00, 3'd3};
        vecs[5] = '{32'h5a000000, 4'hf, 1'b1, 1'b1, 8'h5a, 3'd3};
        vecs[6] = '{32'h00000700, 4'hf, 1'b1, 1'b1, 8'h07, 3'd1};
        vecs[7] = '{32'h9c000700, 4'hd, 1'b1, 1'b1, 8'h9c, 3'd3};
        vecs[8] = '{32'h44332211, 4'hf, 1'b1, 1'b0, 8'h00, 3'd3};
        vecs[9] = '{32'hffeeddcc, 4'h0, 1'b1, 1'b1, 8'h00, 3'd3};

        rst = 1'b1; pxl_cen = 1'b1; LHBL = 1'b1; LVBL = 1'b1; order_we = 1'b0;
        pxl_in = 32'h0; gfx_en = 4'hf; order_in = 12'h0; st_addr = 8'h00;
        step();
        check("rst_pxl", pxl_out, 8'h00);
        check("rst_lyr", lyr_out, 3'd0);
        check("rst_dly", {LHBL_dly, LVBL_dly}, 2'b00);
        check("rst_st", st_dout, 8'h00);
        rst = 1'b0;

        // Table vectors: hold inputs for 3 ticks so the output settles.
        for (int i = 0; i < 10; i++) begin
            pxl_in = vecs[i].pxl; gfx_en = vecs[i].en;
            LHBL = vecs[i].h; LVBL = vecs[i].v;
            steps(3);
            check($sformatf("vec%0d_pxl", i), pxl_out, vecs[i].exp_pxl);
            check($sformatf("vec%0d_lyr", i), lyr_out, vecs[i].exp_lyr);
            check($sformatf("vec%0d_dly", i), {LHBL_dly, LVBL_dly}, {vecs[i].h, vecs[i].v});
        end

        // Shadow write mid-frame; takes effect after the LVBL falling edge.
        LHBL = 1'b1; LVBL = 1'b1; gfx_en = 4'hf; pxl_in = 32'h44332211;
        steps(3);
        order_in = 12'h053; order_we = 1'b1; st_addr = 8'h10;
        step();
        order_we = 1'b0;
        step();
        check("shadow_byte0", st_dout, 8'h53);
        st_addr = 8'h00;
        step();
        check("active_before", st_dout, 8'h88);
        steps(3);
        check("midframe_pxl", pxl_out, 8'h11);
        check("midframe_lyr", lyr_out, 3'd0);
        LVBL = 1'b0;
        steps(2);
        LVBL = 1'b1;
        steps(3);
        check("neword_pxl", pxl_out, 8'h44);
        check("neword_lyr", lyr_out, 3'd3);
        step();
        check("active_after", st_dout, 8'h53);

        // Write during vblank goes straight to active; all IDs out of range.
        LVBL = 1'b0;
        step();
        order_in = 12'hfff; order_we = 1'b1;
        step();
        order_we = 1'b0; st_addr = 8'h00;
        step();
        check("vbl_wr_b0", st_dout, 8'hff);
        st_addr = 8'h01;
        step();
        check("vbl_wr_b1", st_dout, 8'h0f);
        LVBL = 1'b1;
        steps(3);
        check("oor_pxl", pxl_out, 8'h00);
        check("oor_lyr", lyr_out, 3'd7);

        // Duplicate IDs: slots 0..2 all layer 0, backdrop layer 2.
        LVBL = 1'b0;
        step();
        order_in = 12'h400; order_we = 1'b1;
        step();
        order_we = 1'b0; pxl_in = 32'h00350010; LVBL = 1'b1;
        steps(3);
        check("dup_pxl", pxl_out, 8'h35);
        check("dup_lyr", lyr_out, 3'd2);

        // Write in the same clk as the LVBL falling edge.
        LVBL = 1'b0; order_in = 12'h688; order_we = 1'b1;
        step();
        order_we = 1'b0; st_addr = 8'h00;
        step();
        check("same_clk_b0", st_dout, 8'h88);
        st_addr = 8'h01;
        step();
        check("same_clk_b1", st_dout, 8'h06);

        // Reset mid-line discards in-flight pixels.
        LVBL = 1'b1; pxl_in = 32'h44000000;
        steps(3);
        check("pre_rst_pxl", pxl_out, 8'h44);
        check("pre_rst_lyr", lyr_out, 3'd3);
        st_addr = 8'h10;
        step();
        rst = 1'b1;
        step();
        check("midrst_pxl", pxl_out, 8'h00);
        check("midrst_lyr", lyr_out, 3'd0);
        check("midrst_dly", {LHBL_dly, LVBL_dly}, 2'b00);
        check("midrst_st", st_dout, 8'h00);
        rst = 1'b0; pxl_in = 32'h44332211; st_addr = 8'h00;
        step();
        check("post_rst_active", st_dout, 8'h88);
        check("post_rst_t1", pxl_out, 8'h00);
        step();
        check("post_rst_t2", pxl_out, 8'h00);
        step();
        check("post_rst_t3_pxl", pxl_out, 8'h11);
        check("post_rst_t3_lyr", lyr_out, 3'd0);

        // Frame counter and its wrap.
        rst = 1'b1; LVBL = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            LVBL = 1'b0; step(); LVBL = 1'b1; step();
        end
        st_addr = 8'h20;
        step();
        check("frame5", st_dout, 8'd5);
        for (int i = 0; i < 251; i++) begin
            LVBL = 1'b0; step(); LVBL = 1'b1; step();
        end
        step();
        check("frame_wrap", st_dout, 8'd0);
        st_addr = 8'h30;
        step();
        check("st_other", st_dout, 8'hff);

        // Randomised stream against the reference model.
        for (int rnd = 0; rnd < 3; rnd++) begin
            rst = 1'b1; pxl_cen = 1'b0; order_we = 1'b0; LVBL = 1'b1;
            step();
            rst = 1'b0;
            rnd_order = 12'($urandom);
            LVBL = 1'b0; order_in = rnd_order; order_we = 1'b1;
            step();
            order_we = 1'b0;
            hist.delete();
            for (int i = 0; i < 3; i++) hist.push_back('{32'h0, 4'h0, 1'b0, 1'b0});
            exp_p = 8'h00; exp_l = 3'd0; exp_h = 1'b0; exp_v = 1'b0;
            for (int c = 0; c < 400; c++) begin
                for (int k = 0; k < NL; k++) begin
                    byte_v = 8'($urandom);
                    if ($urandom_range(0, 1) == 0) byte_v[3:0] = 4'h0;
                    pxl_in[k*8 +: 8] = byte_v;
                end
                gfx_en  = 4'($urandom);
                LHBL    = $urandom_range(0, 7) != 0;
                LVBL    = $urandom_range(0, 15) != 0;
                pxl_cen = $urandom_range(0, 2) != 0;
                step();
                if (pxl_cen) begin
                    hist.push_back('{pxl_in, gfx_en, LHBL, LVBL});
                    rec = hist[hist.size() - 3];
                    r = ref_mix(rec.pxl, rec.en, rnd_order);
                    exp_h = rec.h;
                    exp_v = rec.v;
                    if (rec.h && rec.v) begin
                        exp_p = r[7:0];
                        exp_l = r[10:8];
                    end else begin
                        exp_p = 8'h00;
                    end
                end
                check($sformatf("rand_r%0d_c%0d", rnd, c),
                      {pxl_out, lyr_out, LHBL_dly, LVBL_dly},
                      {exp_p, exp_l, exp_h, exp_v});
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
